// File: rtl/nn_ctrl_pkg.sv
// Shared constants and types for the layer/row control path.
// State codes stay plain localparams so legacy tools and waveform viewers agree.
package nn_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_ROW_A  = 3'd2;
    localparam logic [2:0] ST_ROW_B  = 3'd3;
    localparam logic [2:0] ST_REWIND = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int ROWS_PER_GROUP = 2;

    localparam logic [3:0] QUAD0_BASE = 4'd0;
    localparam logic [3:0] QUAD1_BASE = 4'd6;

    // One cycle's worth of row-counter strobes, computed together and registered together.
    typedef struct packed {
        logic clear;
        logic new_row;
        logic new_vector;
        logic new_quadrant_row;
    } strobe_t;

    function automatic logic [3:0] quad_base(input logic msb);
        return msb ? QUAD1_BASE : QUAD0_BASE;
    endfunction

endpackage

// File: rtl/row_strobe_sequencer_if.sv
// Handshake and strobe bundle between layer control, the MAC datapath and the row counter.
// The sequencer uses the slave view; whoever drives start/row_done/abort uses master.
interface row_strobe_sequencer_if;

    logic       start;
    logic       quad_sel;
    logic       row_done;
    logic       abort;

    logic       en;
    logic       clear;
    logic       new_row;
    logic       new_vector;
    logic       new_quadrant_row;
    logic       quadrant_msb;
    logic       busy;
    logic       layer_done;
    logic [1:0] group_index;
    logic [3:0] vector_index;

    modport master (
        output start, quad_sel, row_done, abort,
        input  en, clear, new_row, new_vector, new_quadrant_row,
               quadrant_msb, busy, layer_done, group_index, vector_index
    );

    modport slave (
        input  start, quad_sel, row_done, abort,
        output en, clear, new_row, new_vector, new_quadrant_row,
               quadrant_msb, busy, layer_done, group_index, vector_index
    );

endinterface

// File: rtl/seq_index_counter.sv
// Group and vector position within one quadrant layer, with terminal-count flags
// the sequencer uses to decide between rewinding and moving to the next group.
module seq_index_counter #(
    parameter int NUM_VECTORS     = 4,
    parameter int GROUPS_PER_QUAD = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       zero,
    input  logic       vec_inc,
    input  logic       vec_wrap,
    input  logic       grp_inc,
    output logic [1:0] group_index,
    output logic [3:0] vector_index,
    output logic       vec_last,
    output logic       grp_last
);

    localparam logic [3:0] VEC_MAX = 4'(NUM_VECTORS - 1);
    localparam logic [1:0] GRP_MAX = 2'(GROUPS_PER_QUAD - 1);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            group_index  <= '0;
            vector_index <= '0;
        end else if (zero) begin
            group_index  <= '0;
            vector_index <= '0;
        end else begin
            if (vec_wrap) begin
                vector_index <= '0;
            end else if (vec_inc) begin
                vector_index <= vector_index + 4'd1;
            end
            if (grp_inc) begin
                group_index <= group_index + 2'd1;
            end
        end
    end

    assign vec_last = (vector_index == VEC_MAX);
    assign grp_last = (group_index == GRP_MAX);

endmodule

// File: rtl/row_strobe_sequencer.sv
// Walks one quadrant layer as row groups, replaying each group once per input vector,
// and drives the row counter's strobes. Every output is registered.
module row_strobe_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_VECTORS     = 4,
    parameter int GROUPS_PER_QUAD = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    row_strobe_sequencer_if.slave  bus
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    strobe_t    strobe_nxt;
    logic       layer_done_nxt;
    logic       quad_load;
    logic       idx_zero;
    logic       vec_inc;
    logic       vec_wrap;
    logic       grp_inc;
    logic       vec_last;
    logic       grp_last;

    seq_index_counter #(
        .NUM_VECTORS     (NUM_VECTORS),
        .GROUPS_PER_QUAD (GROUPS_PER_QUAD)
    ) u_index (
        .clock        (clock),
        .reset_n      (reset_n),
        .zero         (idx_zero),
        .vec_inc      (vec_inc),
        .vec_wrap     (vec_wrap),
        .grp_inc      (grp_inc),
        .group_index  (bus.group_index),
        .vector_index (bus.vector_index),
        .vec_last     (vec_last),
        .grp_last     (grp_last)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt      = state;
        strobe_nxt     = '0;
        layer_done_nxt = 1'b0;
        quad_load      = 1'b0;
        idx_zero       = 1'b0;
        vec_inc        = 1'b0;
        vec_wrap       = 1'b0;
        grp_inc        = 1'b0;

        if (bus.abort && state != ST_IDLE) begin
            state_nxt        = ST_IDLE;
            strobe_nxt.clear = 1'b1;
            idx_zero         = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nxt        = ST_CLR;
                        strobe_nxt.clear = 1'b1;
                        quad_load        = 1'b1;
                        idx_zero         = 1'b1;
                    end
                end
                ST_CLR: begin
                    state_nxt = ST_ROW_A;
                end
                ST_ROW_A: begin
                    if (bus.row_done) begin
                        strobe_nxt.new_row = 1'b1;
                        state_nxt          = ST_ROW_B;
                    end
                end
                ST_ROW_B: begin
                    if (bus.row_done) begin
                        if (!vec_last) begin
                            strobe_nxt.new_row = 1'b1;
                            state_nxt          = ST_REWIND;
                        end else begin
                            // Group finished: the counter steps past it instead of rewinding.
                            strobe_nxt.new_vector       = 1'b1;
                            strobe_nxt.new_quadrant_row = 1'b1;
                            vec_wrap                    = 1'b1;
                            if (grp_last) begin
                                state_nxt = ST_DONE;
                            end else begin
                                grp_inc   = 1'b1;
                                state_nxt = ST_ROW_A;
                            end
                        end
                    end
                end
                ST_REWIND: begin
                    strobe_nxt.new_vector = 1'b1;
                    vec_inc               = 1'b1;
                    state_nxt             = ST_ROW_A;
                end
                ST_DONE: begin
                    layer_done_nxt = 1'b1;
                    state_nxt      = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            bus.en               <= 1'b0;
            bus.busy             <= 1'b0;
            bus.clear            <= 1'b0;
            bus.new_row          <= 1'b0;
            bus.new_vector       <= 1'b0;
            bus.new_quadrant_row <= 1'b0;
            bus.layer_done       <= 1'b0;
            bus.quadrant_msb     <= 1'b0;
        end else begin
            state                <= state_nxt;
            bus.en               <= (state_nxt != ST_IDLE);
            bus.busy             <= (state_nxt != ST_IDLE);
            bus.clear            <= strobe_nxt.clear;
            bus.new_row          <= strobe_nxt.new_row;
            bus.new_vector       <= strobe_nxt.new_vector;
            bus.new_quadrant_row <= strobe_nxt.new_quadrant_row;
            bus.layer_done       <= layer_done_nxt;
            if (quad_load) begin
                bus.quadrant_msb <= bus.quad_sel;
            end
        end
    end

endmodule

// File: tb/tb_row_strobe_sequencer.sv
// Bench for row_strobe_sequencer: a layer-script model checked every cycle, a behavioural
// row-index counter driven by the strobes, and directed layer scenarios with literal totals.
`timescale 1ns/1ps
module tb_row_strobe_sequencer;
    import nn_ctrl_pkg::*;

    localparam int NV = 4;
    localparam int GQ = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    row_strobe_sequencer_if bus();

    row_strobe_sequencer #(
        .NUM_VECTORS     (NV),
        .GROUPS_PER_QUAD (GQ)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       en;
        logic       clear;
        logic       new_row;
        logic       new_vector;
        logic       new_quadrant_row;
        logic       quadrant_msb;
        logic       busy;
        logic       layer_done;
        logic [1:0] group_index;
        logic [3:0] vector_index;
    } obs_t;

    // One entry per cycle-advancing step of a layer; wait_row steps consume a row_done.
    typedef struct packed {
        logic       wait_row;
        logic       nr;
        logic       nv;
        logic       nqr;
        logic       done;
        logic [1:0] grp;
        logic [3:0] vec;
    } script_t;

    script_t script[$];
    obs_t    exp_o;
    int      m_pc;
    logic    m_active;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.en               = bus.en;
        o.clear            = bus.clear;
        o.new_row          = bus.new_row;
        o.new_vector       = bus.new_vector;
        o.new_quadrant_row = bus.new_quadrant_row;
        o.quadrant_msb     = bus.quadrant_msb;
        o.busy             = bus.busy;
        o.layer_done       = bus.layer_done;
        o.group_index      = bus.group_index;
        o.vector_index     = bus.vector_index;
        return o;
    endfunction

    function automatic script_t mk(input logic w, input logic nr, input logic nv,
                                   input logic nqr, input logic done, input int g, input int v);
        script_t s;
        s.wait_row = w;
        s.nr       = nr;
        s.nv       = nv;
        s.nqr      = nqr;
        s.done     = done;
        s.grp      = 2'(g);
        s.vec      = 4'(v);
        return s;
    endfunction

    task automatic build_script();
        script.delete();
        script.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        for (int g = 0; g < GQ; g++) begin
            for (int v = 0; v < NV; v++) begin
                script.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, g, v));
                if (v < NV - 1) begin
                    script.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, g, v));
                    script.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, g, v + 1));
                end else begin
                    script.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, (g < GQ - 1) ? g + 1 : g, 0));
                end
            end
        end
        script.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, GQ - 1, 0));
    endtask

    // Layer model: interpret the script, one step per edge, with start/abort handled around it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_pc     <= 0;
            exp_o    <= '0;
        end else begin
            exp_o.clear            <= 1'b0;
            exp_o.new_row          <= 1'b0;
            exp_o.new_vector       <= 1'b0;
            exp_o.new_quadrant_row <= 1'b0;
            exp_o.layer_done       <= 1'b0;
            if (!m_active) begin
                if (bus.start && !bus.abort) begin
                    m_active           <= 1'b1;
                    m_pc               <= 0;
                    exp_o.clear        <= 1'b1;
                    exp_o.en           <= 1'b1;
                    exp_o.busy         <= 1'b1;
                    exp_o.quadrant_msb <= bus.quad_sel;
                    exp_o.group_index  <= '0;
                    exp_o.vector_index <= '0;
                end
            end else if (bus.abort) begin
                m_active           <= 1'b0;
                exp_o.clear        <= 1'b1;
                exp_o.en           <= 1'b0;
                exp_o.busy         <= 1'b0;
                exp_o.group_index  <= '0;
                exp_o.vector_index <= '0;
            end else if (!script[m_pc].wait_row || bus.row_done) begin
                exp_o.new_row          <= script[m_pc].nr;
                exp_o.new_vector       <= script[m_pc].nv;
                exp_o.new_quadrant_row <= script[m_pc].nqr;
                exp_o.layer_done       <= script[m_pc].done;
                exp_o.group_index      <= script[m_pc].grp;
                exp_o.vector_index     <= script[m_pc].vec;
                if (m_pc == script.size() - 1) begin
                    m_active   <= 1'b0;
                    exp_o.en   <= 1'b0;
                    exp_o.busy <= 1'b0;
                end
                m_pc <= m_pc + 1;
            end
        end
    end

    always @(negedge clock) begin
        check("cycle", 32'(sample()), 32'(exp_o));
    end

    // Row-index counter fed by the strobes, plus per-run strobe tallies.
    int row = 0, cur_base = 0, layer_row = -1;
    int cnt_nr = 0, cnt_nv = 0, cnt_nqr = 0, cnt_clr = 0, cnt_done = 0;
    int cnt_layer = 0, cnt_multi = 0, ctr_err = 0, qmsb_at_done = -1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (int'(bus.clear) + int'(bus.new_row) + int'(bus.new_vector) > 1 ||
                (bus.clear && (bus.new_quadrant_row || bus.layer_done)))
                cnt_multi++;
            if (bus.clear) cnt_clr++;
            if (bus.new_row) cnt_nr++;
            if (bus.new_vector) cnt_nv++;
            if (bus.new_quadrant_row) cnt_nqr++;
            if (bus.layer_done) begin
                cnt_done++;
                qmsb_at_done = int'(bus.quadrant_msb);
            end
            if (bus.clear) begin
                cur_base = int'(quad_base(bus.quadrant_msb));
                row      = cur_base;
            end else if (bus.new_quadrant_row) begin
                if (row == cur_base + GQ * ROWS_PER_GROUP - 1) begin
                    cnt_layer++;
                    layer_row = row;
                    row       = cur_base;
                end else begin
                    row++;
                end
            end else if (bus.new_vector) begin
                if (row != cur_base + ROWS_PER_GROUP * (int'(bus.group_index) + 1)) ctr_err++;
                row -= 2;
            end else if (bus.new_row) begin
                row++;
            end
            if (row < cur_base || row > cur_base + GQ * ROWS_PER_GROUP) ctr_err++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        cnt_nr = 0; cnt_nv = 0; cnt_nqr = 0; cnt_clr = 0; cnt_done = 0;
        cnt_layer = 0; cnt_multi = 0; ctr_err = 0; layer_row = -1; qmsb_at_done = -1;
    endtask

    task automatic pulse_start(input logic q);
        tick(1);
        bus.start    = 1'b1;
        bus.quad_sel = q;
        tick(1);
        bus.start    = 1'b0;
    endtask

    task automatic rows(input int n, input int gap);
        repeat (n) begin
            tick(gap);
            bus.row_done = 1'b1;
            tick(1);
            bus.row_done = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (cnt_done == 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("layer_done_seen", (cnt_done > 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_layer(input int base);
        check("new_row_count", cnt_nr, 21);
        check("new_vector_count", cnt_nv, 12);
        check("new_quadrant_row_count", cnt_nqr, 3);
        check("clear_count", cnt_clr, 1);
        check("layer_done_count", cnt_done, 1);
        check("new_layer_count", cnt_layer, 1);
        check("new_layer_row", layer_row, base + 5);
        check("row_contract_errors", ctr_err, 0);
        check("strobe_overlap", cnt_multi, 0);
        check("row_after_layer", row, base);
        check("qmsb_at_done", qmsb_at_done, (base != 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.quad_sel = 1'b0;
        bus.row_done = 1'b0;
        bus.abort    = 1'b0;
        build_script();
        #2 reset_n = 1'b0;
        tick(3);
        check("reset_outputs", 32'(sample()), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Async reset part-way through a layer: everything drops at once, no clear.
        pulse_start(1'b1);
        rows(5, 2);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'(sample()), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("busy_after_reset", 32'(bus.busy), 32'd0);

        clear_counts();
        pulse_start(1'b0);
        rows(24, 2);
        wait_done(20);
        tick(2);
        check_layer(0);

        clear_counts();
        pulse_start(1'b1);
        rows(24, 2);
        wait_done(20);
        tick(2);
        check_layer(6);

        clear_counts();
        pulse_start(1'b0);
        bus.row_done = 1'b1;
        wait_done(200);
        bus.row_done = 1'b0;
        tick(2);
        check_layer(0);

        clear_counts();
        pulse_start(1'b0);
        rows(5, 2);
        pulse_start(1'b1);
        rows(19, 2);
        wait_done(20);
        tick(2);
        check_layer(0);

        // Abort after 10 rows: a lone clear, idle next cycle, counter back at base.
        pulse_start(1'b0);
        rows(10, 2);
        tick(3);
        clear_counts();
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("busy_after_abort", 32'(bus.busy), 32'd0);
        check("clear_on_abort", 32'(bus.clear), 32'd1);
        tick(3);
        check("abort_clear_count", cnt_clr, 1);
        check("abort_no_done", cnt_done, 0);
        check("abort_other_strobes", cnt_nr + cnt_nv + cnt_nqr, 0);
        check("abort_row_base", row, 0);

        // start together with abort in IDLE is dropped.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle_busy", 32'(bus.busy), 32'd0);
        check("start_abort_idle_clear", 32'(bus.clear), 32'd0);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
